mrdy_gen: RTL and testbench

- Wait-state generator feeding MRDY to the MMU's Q/E clock generator.
- Decodes each bus cycle's address region and holds MRDY low for a programmed number of CLKX4 cycles during E-high/Q-low phase (01). This stretches E for slow ROM, IO and external devices.
- Also extends cycles on an external wait request, with a timeout guard.
- Owns two CPU-visible registers, FF92 (wait config) and FF93 (status).

---
 rtl/mrdy_gen.sv | 170 +++++++++++++++++
 tb/tb_mrdy_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mrdy_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mrdy_gen
//  Description : Wait-state generator driving MRDY into the MMU Q/E clock
//                generator; also owns the FF92 config and FF93 status regs.
//  Revision    : 1.0  initial release
// ============================================================================
module mrdy_gen #(
   parameter logic [7:0] RESET_CFG   = 8'hFF,
   parameter int         TIMEOUT_MAX = 255
) (
   input  logic        CLKX4,
   input  logic        nRESET,
   input  logic        QX,
   input  logic        EX,
   input  logic [15:0] ADDR,
   input  logic [7:0]  DATA,
   input  logic        RnW,
   input  logic        BA,
   input  logic        nEXTWAIT,
   output logic        MRDY,
   output logic [7:0]  DOUT,
   output logic        DOE,
   output logic        TIMEOUT
);

   // {QX,EX} phase codes of interest
   localparam logic [1:0] c_PH_LOAD    = 2'b11;
   localparam logic [1:0] c_PH_STRETCH = 2'b01;

   localparam logic [1:0] c_RGN_INT = 2'd0;
   localparam logic [1:0] c_RGN_ROM = 2'd1;
   localparam logic [1:0] c_RGN_IO  = 2'd2;
   localparam logic [1:0] c_RGN_RAM = 2'd3;

   localparam logic [0:0] c_XW_IDLE = 1'b0;
   localparam logic [0:0] c_XW_HOLD = 1'b1;

   localparam logic [7:0]  c_TCNT_LAST  = 8'(TIMEOUT_MAX - 1);
   localparam logic [15:0] c_ADDR_CFG   = 16'hFF92;
   localparam logic [15:0] c_ADDR_STAT  = 16'hFF93;

   logic [1:0] w_phase;
   logic       w_isLoad;
   logic       w_isStretch;
   logic [1:0] w_region;
   logic [2:0] w_regionWaits;
   logic       w_extRegion;
   logic       w_cntBusy;
   logic       w_xwStart;
   logic       w_xwExpired;
   logic       w_xwHold;
   logic       w_xwTimeout;
   logic       w_cycleEnd;
   logic       w_hitCfg;
   logic       w_hitStat;

   logic [2:0] r_waitCnt;
   logic [0:0] r_xwState;
   logic [7:0] r_tCnt;
   logic [7:0] r_cfg;
   logic       r_timeout;

   assign w_phase     = {QX, EX};
   assign w_isLoad    = (w_phase == c_PH_LOAD);
   assign w_isStretch = (w_phase == c_PH_STRETCH);
   assign w_hitCfg    = (ADDR == c_ADDR_CFG);
   assign w_hitStat   = (ADDR == c_ADDR_STAT);

   // Priority decode: the internal page wins over the vector page, which
   // wins over IO, which wins over the general ROM window.
   always_comb begin
      w_region = c_RGN_RAM;
      if ((ADDR[15:8] == 8'hFF) && (ADDR[7:4] != 4'hF)) begin
         w_region = c_RGN_INT;
      end else if (ADDR[15:4] == 12'hFFF) begin
         w_region = c_RGN_ROM;
      end else if (ADDR[15:8] == 8'hFE) begin
         w_region = c_RGN_IO;
      end else if (ADDR[15:14] == 2'b11) begin
         w_region = c_RGN_ROM;
      end
   end

   always_comb begin
      w_regionWaits = 3'd0;
      case (w_region)
         c_RGN_ROM: w_regionWaits = r_cfg[2:0];
         c_RGN_IO:  w_regionWaits = r_cfg[5:3];
         c_RGN_RAM: w_regionWaits = {1'b0, r_cfg[7:6]};
         default:   w_regionWaits = 3'd0;
      endcase
   end

   assign w_extRegion = (w_region == c_RGN_IO) || (ADDR[15:14] == 2'b10);
   assign w_cntBusy   = (r_waitCnt != 3'd0);

   // External wait only begins once the programmed waits have run out.
   assign w_xwStart   = w_isStretch && !w_cntBusy && !nEXTWAIT && w_extRegion
                        && (r_xwState == c_XW_IDLE);
   assign w_xwExpired = (r_xwState == c_XW_HOLD) && (r_tCnt == c_TCNT_LAST);
   assign w_xwHold    = w_isStretch && !w_cntBusy && !nEXTWAIT
                        && ((r_xwState == c_XW_IDLE) ? w_extRegion : !w_xwExpired);
   assign w_xwTimeout = w_isStretch && !w_cntBusy && !nEXTWAIT && w_xwExpired;

   assign MRDY       = !(w_isStretch && (w_cntBusy || w_xwHold));
   assign w_cycleEnd = w_isStretch && MRDY;

   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         r_waitCnt <= 3'd0;
      end else if (w_isLoad) begin
         r_waitCnt <= BA ? 3'd0 : w_regionWaits;
      end else if (w_isStretch && w_cntBusy) begin
         r_waitCnt <= r_waitCnt - 3'd1;
      end
   end

   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         r_xwState <= c_XW_IDLE;
         r_tCnt    <= 8'd0;
      end else if (r_xwState == c_XW_IDLE) begin
         if (w_xwStart) begin
            r_xwState <= c_XW_HOLD;
            r_tCnt    <= 8'd0;
         end
      end else begin
         if (w_xwHold) begin
            r_tCnt <= r_tCnt + 8'd1;
         end else begin
            r_xwState <= c_XW_IDLE;
            r_tCnt    <= 8'd0;
         end
      end
   end

   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         r_cfg <= RESET_CFG;
      end else if (w_cycleEnd && !RnW && w_hitCfg) begin
         r_cfg <= DATA;
      end
   end

   // A timeout landing on the same edge as a status write must stay visible.
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         r_timeout <= 1'b0;
      end else if (w_xwTimeout) begin
         r_timeout <= 1'b1;
      end else if (w_cycleEnd && !RnW && w_hitStat) begin
         r_timeout <= 1'b0;
      end
   end

   assign TIMEOUT = r_timeout;
   assign DOE     = EX && RnW && (w_hitCfg || w_hitStat);

   always_comb begin
      DOUT = 8'h00;
      if (w_hitCfg) begin
         DOUT = r_cfg;
      end else if (w_hitStat) begin
         DOUT = {7'b0, r_timeout};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mrdy_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mrdy_gen
//  Description : Self-checking bench for mrdy_gen with an MMU phase model and
//                a region/wait reference model; directed plus random cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mrdy_gen;

   localparam int c_TMAX = 16;

   logic        CLKX4 = 1'b0;
   logic        nRESET;
   logic        QX;
   logic        EX;
   logic [15:0] ADDR;
   logic [7:0]  DATA;
   logic        RnW;
   logic        BA;
   logic        nEXTWAIT;
   logic        MRDY;
   logic [7:0]  DOUT;
   logic        DOE;
   logic        TIMEOUT;

   int nChecks = 0;
   int nPass   = 0;
   int nFail   = 0;

   logic [7:0] mCfg;
   logic       mTo;

   mrdy_gen #(
      .RESET_CFG   (8'hFF),
      .TIMEOUT_MAX (c_TMAX)
   ) dut (
      .CLKX4    (CLKX4),
      .nRESET   (nRESET),
      .QX       (QX),
      .EX       (EX),
      .ADDR     (ADDR),
      .DATA     (DATA),
      .RnW      (RnW),
      .BA       (BA),
      .nEXTWAIT (nEXTWAIT),
      .MRDY     (MRDY),
      .DOUT     (DOUT),
      .DOE      (DOE),
      .TIMEOUT  (TIMEOUT)
   );

   always #5 CLKX4 = ~CLKX4;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int expWaits(input logic [15:0] a, input logic [7:0] cfg, input logic ba);
      if (ba) return 0;
      if (a >= 16'hFF00 && a <= 16'hFFEF) return 0;
      if (a >= 16'hFFF0) return int'(cfg[2:0]);
      if (a >= 16'hFE00 && a <= 16'hFEFF) return int'(cfg[5:3]);
      if (a >= 16'hC000) return int'(cfg[2:0]);
      return int'(cfg[7:6]);
   endfunction

   function automatic logic isExt(input logic [15:0] a);
      return (a >= 16'hFE00 && a <= 16'hFEFF) || (a >= 16'h8000 && a <= 16'hBFFF);
   endfunction

   // One full bus cycle through 00 -> 10 -> 11 -> 01(stretched) with nEXTWAIT
   // held low for the first extLow edges of the E-high/Q-low phase.
   task automatic busCycle(input string tag, input logic [15:0] a, input logic [7:0] d,
                           input logic rnw, input logic ba, input int extLow);
      int         n, xwLen, expLow, lowCnt, e01;
      logic       expTo, expDoe, mrdyOff, doeOff, doeSeen, done;
      logic [7:0] expDout, doutSeen;
      n      = expWaits(a, mCfg, ba);
      xwLen  = isExt(a) ? extLow - n : 0;
      if (xwLen < 0) xwLen = 0;
      expTo  = xwLen > c_TMAX;
      expLow = n + (expTo ? c_TMAX : xwLen);
      expDoe = rnw && (a == 16'hFF92 || a == 16'hFF93);
      expDout = (a == 16'hFF92) ? mCfg : (a == 16'hFF93) ? {7'b0, mTo} : 8'h00;

      ADDR = a; DATA = d; RnW = rnw; BA = ba; nEXTWAIT = 1'b1;
      @(negedge CLKX4); mrdyOff = MRDY; doeOff = DOE;
      @(posedge CLKX4); #1; QX = 1'b1; EX = 1'b0;
      @(negedge CLKX4); mrdyOff &= MRDY; doeOff |= DOE;
      @(posedge CLKX4); #1; QX = 1'b1; EX = 1'b1;
      @(negedge CLKX4); mrdyOff &= MRDY; doeSeen = DOE; doutSeen = DOUT;
      @(posedge CLKX4); #1; QX = 1'b0; EX = 1'b1;
      lowCnt = 0; e01 = 0; done = 1'b0;
      while (!done && e01 < 300) begin
         nEXTWAIT = (e01 < extLow) ? 1'b0 : 1'b1;
         @(negedge CLKX4);
         if (MRDY) done = 1'b1;
         else lowCnt++;
         @(posedge CLKX4); #1;
         e01++;
      end
      QX = 1'b0; EX = 1'b0; nEXTWAIT = 1'b1; RnW = 1'b1;

      if (!rnw && a == 16'hFF92) mCfg = d;
      if (expTo) mTo = 1'b1;
      else if (!rnw && a == 16'hFF93) mTo = 1'b0;

      check({tag, " cycle_ended"}, 32'(done), 32'd1);
      check({tag, " mrdy_low_cnt"}, 32'(lowCnt), 32'(expLow));
      check({tag, " mrdy_high_outside_01"}, 32'(mrdyOff), 32'd1);
      check({tag, " doe_low_when_e_low"}, 32'(doeOff), 32'd0);
      check({tag, " doe"}, 32'(doeSeen), 32'(expDoe));
      check({tag, " dout"}, 32'(doutSeen), 32'(expDout));
      check({tag, " timeout"}, 32'(TIMEOUT), 32'(mTo));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cat;
      logic [15:0] a;

      nRESET = 1'b0; QX = 1'b0; EX = 1'b0; ADDR = 16'h0000; DATA = 8'h00;
      RnW = 1'b1; BA = 1'b0; nEXTWAIT = 1'b1;
      mCfg = 8'hFF; mTo = 1'b0;
      repeat (3) @(posedge CLKX4);
      #2;
      check("reset mrdy", 32'(MRDY), 32'd1);
      check("reset timeout", 32'(TIMEOUT), 32'd0);
      check("reset doe_idle", 32'(DOE), 32'd0);
      ADDR = 16'hFF92; EX = 1'b1; #1;
      check("reset doe_ff92", 32'(DOE), 32'd1);
      check("reset cfg", 32'(DOUT), 32'hFF);
      EX = 1'b0; ADDR = 16'h0000;
      @(posedge CLKX4); #1; nRESET = 1'b1;

      busCycle("ram_1234", 16'h1234, 8'h00, 1'b1, 1'b0, 0);
      busCycle("wr_cfg00", 16'hFF92, 8'h00, 1'b0, 1'b0, 0);
      busCycle("rom_c000", 16'hC000, 8'h00, 1'b1, 1'b0, 0);
      busCycle("rd_ff92", 16'hFF92, 8'h00, 1'b1, 1'b0, 0);
      busCycle("wr_cfg28", 16'hFF92, 8'h28, 1'b0, 1'b0, 0);
      busCycle("io_fe00", 16'hFE00, 8'h00, 1'b1, 1'b0, 0);
      busCycle("rom_e000", 16'hE000, 8'h00, 1'b1, 1'b0, 0);
      busCycle("int_ff91", 16'hFF91, 8'h00, 1'b1, 1'b0, 0);
      busCycle("wr_cfg00b", 16'hFF92, 8'h00, 1'b0, 1'b0, 0);
      busCycle("xw_10", 16'hFE08, 8'h00, 1'b1, 1'b0, 10);
      busCycle("xw_timeout", 16'hFE08, 8'h00, 1'b1, 1'b0, 30);
      busCycle("rd_ff93_set", 16'hFF93, 8'h00, 1'b1, 1'b0, 0);
      busCycle("wr_ff93", 16'hFF93, 8'h00, 1'b0, 1'b0, 0);
      busCycle("rd_ff93_clr", 16'hFF93, 8'h00, 1'b1, 1'b0, 0);
      busCycle("ba_ram", 16'h0100, 8'h00, 1'b1, 1'b1, 0);

      // Arm a timeout, then reset in the middle of a 4-wait IO stretch.
      busCycle("xw_timeout2", 16'hFE40, 8'h00, 1'b1, 1'b0, 40);
      busCycle("wr_cfg20", 16'hFF92, 8'h20, 1'b0, 1'b0, 0);
      ADDR = 16'hFE10; RnW = 1'b1; BA = 1'b0; nEXTWAIT = 1'b1;
      @(posedge CLKX4); #1; QX = 1'b1; EX = 1'b0;
      @(posedge CLKX4); #1; QX = 1'b1; EX = 1'b1;
      @(posedge CLKX4); #1; QX = 1'b0; EX = 1'b1;
      @(negedge CLKX4);
      check("midstretch mrdy_low", 32'(MRDY), 32'd0);
      #1; nRESET = 1'b0; #1;
      check("midstretch reset mrdy", 32'(MRDY), 32'd1);
      check("midstretch reset timeout", 32'(TIMEOUT), 32'd0);
      mCfg = 8'hFF; mTo = 1'b0;
      QX = 1'b0; EX = 1'b0;
      @(posedge CLKX4); #1; nRESET = 1'b1;
      busCycle("rd_ff92_reset", 16'hFF92, 8'h00, 1'b1, 1'b0, 0);
      busCycle("ram_after_reset", 16'h0400, 8'h00, 1'b1, 1'b0, 0);

      for (int i = 0; i < 60; i++) begin
         cat = int'($urandom_range(0, 7));
         case (cat)
            0:       a = 16'($urandom_range(16'h0000, 16'h7FFF));
            1:       a = 16'($urandom_range(16'h8000, 16'hBFFF));
            2:       a = 16'($urandom_range(16'hC000, 16'hFDFF));
            3:       a = 16'($urandom_range(16'hFE00, 16'hFEFF));
            4:       a = 16'($urandom_range(16'hFF00, 16'hFFEF));
            5:       a = 16'($urandom_range(16'hFFF0, 16'hFFFF));
            default: a = ($urandom_range(0, 1) == 0) ? 16'hFF92 : 16'hFF93;
         endcase
         busCycle($sformatf("rnd%0d", i), a, 8'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 24)));
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
